// File: rtl/instruction_cache_controller_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// block geometry and the tag-width derivation.
package instruction_cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_VALUE   = 32'hFFFF_FFFC;
  localparam int          BLOCK_BITS       = 128;
  localparam int          WORD_OFFSET_BITS = 2;
  localparam int          BYTE_OFFSET_BITS = 2;

  function automatic int tag_width(input int index_bits);
    return 32 - BYTE_OFFSET_BITS - WORD_OFFSET_BITS - index_bits;
  endfunction

endpackage

// File: rtl/instruction_cache_controller_line_array.sv
// Line storage for the instruction cache: valid/tag/data per line with a
// combinational read port and one synchronous write port.
module icache_line_array
  import instruction_cache_controller_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = tag_width(3)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [BLOCK_BITS-1:0] blocks[LINES];

  // Only the valid bits are reset; stale tag/data are harmless behind valid=0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tags[wr_index]   <= wr_tag;
      blocks[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = blocks[rd_index];

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache controller: combinational hit path to the
// PC stage and a miss FSM that refills a 128-bit line from instruction memory.
module instruction_cache_controller
  import instruction_cache_controller_pkg::*;
#(
  parameter int          INDEX_BITS = 3,
  parameter logic [31:0] RESET_PC   = RESET_PC_VALUE
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [31:0]           ADDRESS,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  IMEM_READ,
  output logic [27:0]           IMEM_ADDRESS,
  input  logic [BLOCK_BITS-1:0] IMEM_READDATA,
  input  logic                  IMEM_BUSYWAIT
);

  localparam int TAG_BITS = tag_width(INDEX_BITS);

  state_t state, next_state;

  logic                  seen_busy;
  logic [27:0]           miss_addr;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [1:0]            offset;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [BLOCK_BITS-1:0] rd_data;
  logic                  lookup;
  logic                  hit;
  logic                  capture;
  logic [31:0]           word;
  logic                  unused_addr_bits;

  assign offset = ADDRESS[3:2];
  assign index  = ADDRESS[3+INDEX_BITS:4];
  assign tag    = ADDRESS[31:4+INDEX_BITS];
  assign unused_addr_bits = ^ADDRESS[1:0];

  icache_line_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_lines (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .rd_index(index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (capture),
    .wr_index(miss_addr[INDEX_BITS-1:0]),
    .wr_tag  (miss_addr[27:INDEX_BITS]),
    .wr_data (IMEM_READDATA)
  );

  // The reset PC value is not a real fetch, so it never looks up.
  assign lookup  = (state == IDLE) && (ADDRESS != RESET_PC);
  assign hit     = lookup && rd_valid && (rd_tag == tag);
  assign capture = (state == MEM_READ) && seen_busy && !IMEM_BUSYWAIT;

  always_comb begin
    word = '0;
    case (offset)
      2'd0: word = rd_data[31:0];
      2'd1: word = rd_data[63:32];
      2'd2: word = rd_data[95:64];
      2'd3: word = rd_data[127:96];
      default: word = '0;
    endcase
  end

  always_comb begin
    next_state  = state;
    BUSYWAIT    = 1'b0;
    INSTRUCTION = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          INSTRUCTION = word;
        end else if (lookup) begin
          BUSYWAIT   = 1'b1;
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        BUSYWAIT = 1'b1;
        if (capture) next_state = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Data is only trusted after memory has been seen busy and then released.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      IMEM_READ <= 1'b0;
      miss_addr <= '0;
      seen_busy <= 1'b0;
    end else begin
      state     <= next_state;
      IMEM_READ <= (next_state == MEM_READ);
      if (state == IDLE && next_state == MEM_READ) begin
        miss_addr <= ADDRESS[31:4];
      end
      if (state == MEM_READ && !capture) begin
        seen_busy <= seen_busy | IMEM_BUSYWAIT;
      end else begin
        seen_busy <= 1'b0;
      end
    end
  end

  assign IMEM_ADDRESS = miss_addr;

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Scoreboard bench for instruction_cache_controller: a driver issues fetches
// and queues expectations from a line-level model; a monitor checks completions.
module tb_instruction_cache_controller;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          busy;
    bit          miss;
    logic [27:0] blk;
  } expect_t;

  logic         CLK;
  logic         RESET_N;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         IMEM_READ;
  logic [27:0]  IMEM_ADDRESS;
  logic [127:0] IMEM_READDATA;
  logic         IMEM_BUSYWAIT;

  int compared   = 0;
  int mismatched = 0;

  expect_t     exp_q[$];
  bit          model_valid[8];
  logic [27:0] model_blk[8];
  int          mem_latency  = 1;
  int          mem_predelay = 0;
  logic [27:0] mem_blk;
  bit          mem_abort;

  instruction_cache_controller dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .IMEM_READ    (IMEM_READ),
    .IMEM_ADDRESS (IMEM_ADDRESS),
    .IMEM_READDATA(IMEM_READDATA),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory image: each word holds its own word address plus one.
  function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
    logic [31:0] v;
    v = {2'b00, blk, w};
    return v + 32'd1;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  // Instruction memory: optional idle cycles, then busy for the latency, then data.
  initial begin
    IMEM_BUSYWAIT = 1'b0;
    IMEM_READDATA = '0;
    forever begin
      @(posedge CLK); #1;
      if (IMEM_READ) begin
        mem_blk   = IMEM_ADDRESS;
        mem_abort = 1'b0;
        for (int p = 0; p < mem_predelay && !mem_abort; p++) begin
          @(posedge CLK); #1;
          if (!IMEM_READ) mem_abort = 1'b1;
        end
        if (!mem_abort) begin
          IMEM_BUSYWAIT = 1'b1;
          for (int k = 0; k < mem_latency && !mem_abort; k++) begin
            @(posedge CLK); #1;
            if (!IMEM_READ) mem_abort = 1'b1;
          end
        end
        IMEM_READDATA = mem_block(mem_blk);
        IMEM_BUSYWAIT = 1'b0;
      end
    end
  end

  // Monitor: accumulates stall behaviour and checks each fetch as it completes.
  initial begin
    int      busy_cnt;
    bit      read_seen;
    logic [27:0] seen_addr;
    expect_t e;
    busy_cnt  = 0;
    read_seen = 0;
    seen_addr = '0;
    forever begin
      @(negedge CLK);
      if (!RESET_N || exp_q.size() == 0) begin
        busy_cnt  = 0;
        read_seen = 0;
      end else if (BUSYWAIT) begin
        busy_cnt++;
        if (IMEM_READ) begin
          read_seen = 1;
          seen_addr = IMEM_ADDRESS;
        end
      end else begin
        e = exp_q.pop_front();
        check_output($sformatf("instr@%h", e.addr), INSTRUCTION, e.instr);
        check_output($sformatf("busy_cycles@%h", e.addr), busy_cnt, e.busy);
        check_output($sformatf("imem_read_seen@%h", e.addr), {31'd0, read_seen}, {31'd0, e.miss});
        if (e.miss) begin
          check_output($sformatf("imem_address@%h", e.addr), {4'd0, seen_addr}, {4'd0, e.blk});
        end
        busy_cnt  = 0;
        read_seen = 0;
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] addr, input int lat, input int pre);
    expect_t e;
    int      idx;
    bit      done;
    idx          = int'(addr[6:4]);
    mem_latency  = lat;
    mem_predelay = pre;
    e.addr = addr;
    e.blk  = addr[31:4];
    if (addr == RESET_PC) begin
      e.instr = '0;
      e.busy  = 0;
      e.miss  = 0;
    end else if (model_valid[idx] && model_blk[idx] == addr[31:4]) begin
      e.instr = mem_word(addr[31:4], addr[3:2]);
      e.busy  = 0;
      e.miss  = 0;
    end else begin
      e.instr = mem_word(addr[31:4], addr[3:2]);
      e.busy  = 3 + lat + pre;
      e.miss  = 1;
      model_valid[idx] = 1;
      model_blk[idx]   = addr[31:4];
    end
    exp_q.push_back(e);
    ADDRESS = addr;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL fetch_timeout@%h: BUSYWAIT still %b, expected 0 within 100 cycles", addr, BUSYWAIT);
      finish_run();
    end
    @(posedge CLK); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_valid[i] = 0;
  endtask

  initial begin
    logic [31:0] a;
    bit          got_read;
    clear_model();
    RESET_N = 1'b0;
    ADDRESS = RESET_PC;
    #12;
    check_output("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check_output("reset_instruction", INSTRUCTION, 32'd0);
    check_output("reset_imem_read", {31'd0, IMEM_READ}, 32'd0);
    check_output("reset_imem_address", {4'd0, IMEM_ADDRESS}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    repeat (3) apply_stimulus(RESET_PC, 1, 0);
    apply_stimulus(32'h0000_0000, 3, 0);
    apply_stimulus(32'h0000_0004, 1, 0);
    apply_stimulus(32'h0000_0008, 1, 0);
    apply_stimulus(32'h0000_000C, 1, 0);
    apply_stimulus(32'h0000_0080, 2, 0);
    apply_stimulus(32'h0000_0084, 1, 0);
    apply_stimulus(32'h0000_0000, 1, 0);
    apply_stimulus(32'h0000_0044, 2, 1);
    apply_stimulus(32'h0000_0048, 1, 0);

    // Reset pulled in the middle of a refill.
    mem_latency  = 4;
    mem_predelay = 0;
    ADDRESS      = 32'h0000_0100;
    got_read     = 0;
    for (int c = 0; c < 20 && !got_read; c++) begin
      @(posedge CLK); #1;
      if (IMEM_READ) got_read = 1;
    end
    check_output("refill_started", {31'd0, got_read}, 32'd1);
    @(posedge CLK); #3;
    RESET_N = 1'b0;
    #1;
    check_output("midfill_reset_imem_read", {31'd0, IMEM_READ}, 32'd0);
    check_output("midfill_reset_imem_address", {4'd0, IMEM_ADDRESS}, 32'd0);
    check_output("midfill_reset_busywait", {31'd0, BUSYWAIT}, 32'd1);
    clear_model();
    ADDRESS = RESET_PC;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    apply_stimulus(32'h0000_0100, 2, 0);
    apply_stimulus(32'h0000_0104, 1, 0);
    apply_stimulus(32'h0000_0000, 1, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        a = RESET_PC;
      end else begin
        a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      end
      apply_stimulus(a, int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    repeat (3) @(posedge CLK);
    check_output("scoreboard_drained", exp_q.size(), 32'd0);
    finish_run();
  end

endmodule
